// File: rtl/sqrt_share_ctrl_pkg.sv
// sqrt_share_ctrl_pkg: state encodings and default sizes
// for the shared square-root controller.
package sqrt_share_ctrl_pkg;

  localparam int XW_DEF      = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_rr_pick.sv
// sqrt_rr_pick: two-way round-robin picker.
// i_last names the requester served most recently.
module sqrt_rr_pick (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // Lone request wins; a tie goes to whoever was not served last
  always_comb begin
    o_grant = 2'b00;
    unique case ({i_req1, i_req0})
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// sqrt_share_ctrl: shares one sequential sqrt core
// between two requesters, with a core watchdog.
module sqrt_share_ctrl
  import sqrt_share_ctrl_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int RW      = XW / 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic [XW-1:0] xin0,
  output logic          ack0,
  output logic          done0,
  output logic [RW-1:0] root0,
  input  logic          req1,
  input  logic [XW-1:0] xin1,
  output logic          ack1,
  output logic          done1,
  output logic [RW-1:0] root1,
  output logic          core_start,
  output logic [XW-1:0] core_xin,
  input  logic          core_busy,
  input  logic          core_done,
  input  logic [RW-1:0] core_root,
  output logic          timeout,
  input  logic          clr_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]    w_grant;
  logic          w_cap;
  logic          w_start;
  logic          w_fin;
  logic          w_abort;
  logic          w_ret;
  logic          w_wdog_hit;
  logic [RW-1:0] w_res;

  logic          r_owner;
  logic          r_last;
  logic [WDW-1:0] r_wdog;
  logic [XW-1:0] r_xin;
  logic [RW-1:0] r_root0;
  logic [RW-1:0] r_root1;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_done0;
  logic          r_done1;
  logic          r_start;
  logic          r_timeout;

  sqrt_rr_pick u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_wdog_hit = (r_wdog == WDW'(TIMEOUT));
  assign w_res      = w_fin ? core_root : '0;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and per-cycle action strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_start     = 1'b0;
    w_fin       = 1'b0;
    w_abort     = 1'b0;
    w_ret       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!core_busy) begin
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_RETURN;
        end else if (w_wdog_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_RETURN;
        end
      end
      ST_RETURN: begin
        w_ret       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake pulses toward requesters and core
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_ack0  <= w_cap & w_grant[0];
      r_ack1  <= w_cap & w_grant[1];
      r_start <= w_start;
      r_done0 <= w_ret & ~r_owner;
      r_done1 <= w_ret & r_owner;
    end
  end

  // Operand capture, ownership and fairness pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_xin   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      if (w_cap) begin
        r_owner <= w_grant[1];
        r_xin   <= w_grant[1] ? xin1 : xin0;
      end
      if (w_ret) r_last <= r_owner;
    end
  end

  // Only the owner's root is ever written
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_root0 <= '0;
      r_root1 <= '0;
    end else if (w_fin || w_abort) begin
      if (r_owner) r_root1 <= w_res;
      else         r_root0 <= w_res;
    end
  end

  // Watchdog: restarts on core_start, saturates while stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (w_start) begin
      r_wdog <= '0;
    end else if (r_state == ST_ISSUE) begin
      if (r_wdog != {WDW{1'b1}}) r_wdog <= r_wdog + 1'b1;
    end else if (r_state == ST_WAIT) begin
      if (!w_wdog_hit) r_wdog <= r_wdog + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout beats a clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         r_timeout <= 1'b0;
    else if (w_abort)     r_timeout <= 1'b1;
    else if (clr_timeout) r_timeout <= 1'b0;
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign root0      = r_root0;
  assign root1      = r_root1;
  assign core_start = r_start;
  assign core_xin   = r_xin;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// tb_sqrt_share_ctrl: bench for the shared sqrt controller
// with a 17-cycle behavioural core and a root scoreboard.
module tb_sqrt_share_ctrl;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] xin0 = '0;
  logic [31:0] xin1 = '0;
  logic        clr_timeout = 1'b0;
  logic        ack0, ack1, done0, done1;
  logic [15:0] root0, root1;
  logic        core_start, core_busy, core_done, timeout;
  logic [31:0] core_xin;
  logic [15:0] core_root;

  logic        force_busy = 1'b0;
  logic        spur = 1'b0;
  bit          m_hang = 1'b0;
  logic [5:0]  m_cnt;
  logic [31:0] m_x;
  logic        m_done;
  logic [15:0] m_root;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;
  int n_start = 0;
  int t_ack = 0, t_start = 0, t_cdone = 0, t_done = 0;
  int t_to = 0, t_req = 0;
  bit to_q = 1'b0;
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int glog[$];

  typedef struct {
    int          sel;
    logic [31:0] x;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[8];

  sqrt_share_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0        (req0),
    .xin0        (xin0),
    .ack0        (ack0),
    .done0       (done0),
    .root0       (root0),
    .req1        (req1),
    .xin1        (xin1),
    .ack1        (ack1),
    .done1       (done1),
    .root1       (root1),
    .core_start  (core_start),
    .core_xin    (core_xin),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .core_root   (core_root),
    .timeout     (timeout),
    .clr_timeout (clr_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [33:0] r;
    logic [33:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (34'd1 << b);
      if (t * t <= {2'b00, x}) r = t;
    end
    return r[15:0];
  endfunction

  assign core_busy = (m_cnt != 6'd0) | force_busy;
  assign core_done = m_done | spur;
  assign core_root = m_root;

  // Core model: 17 cycles from start to a done pulse
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_root <= '0;
      m_x    <= '0;
    end else begin
      m_done <= 1'b0;
      if (core_start && !m_hang) begin
        m_cnt <= 6'd17;
        m_x   <= core_xin;
      end else if (m_cnt != 6'd0) begin
        m_cnt <= m_cnt - 6'd1;
        if (m_cnt == 6'd1) begin
          m_done <= 1'b1;
          m_root <= isqrt(m_x);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor + scoreboard, sampled on the falling edge
  always @(negedge clock) begin
    logic [15:0] e;
    cyc++;
    if (ack0) begin
      n_ack0++;
      t_ack = cyc;
      glog.push_back(0);
      exp0.push_back(m_hang ? 16'd0 : isqrt(xin0));
    end
    if (ack1) begin
      n_ack1++;
      t_ack = cyc;
      glog.push_back(1);
      exp1.push_back(m_hang ? 16'd0 : isqrt(xin1));
    end
    if (core_start) begin
      n_start++;
      t_start = cyc;
    end
    if (core_done) t_cdone = cyc;
    if (timeout && !to_q) t_to = cyc;
    to_q = timeout;
    if (done0) begin
      n_done0++;
      t_done = cyc;
      if (exp0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_done0 unexpected root0=%0d", root0);
      end else begin
        e = exp0.pop_front();
        chk("sb_root0", root0, e);
      end
    end
    if (done1) begin
      n_done1++;
      t_done = cyc;
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_done1 unexpected root1=%0d", root1);
      end else begin
        e = exp1.pop_front();
        chk("sb_root1", root1, e);
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return ack0;
      1:       return ack1;
      2:       return done0;
      3:       return done1;
      4:       return core_start;
      default: return timeout;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (sig(w)) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic do_req(input int idx, input logic [31:0] x);
    bit ok;
    @(negedge clock);
    #1;
    t_req = cyc;
    if (idx == 0) begin xin0 = x; req0 = 1'b1; end
    else          begin xin1 = x; req1 = 1'b1; end
    wait_sig(idx, 200, ok);
    if (idx == 0) req0 = 1'b0;
    else          req1 = 1'b0;
    chk("ack_seen", ok, 1);
    if (ok) begin
      wait_sig(idx + 2, 300, ok);
      chk("done_seen", ok, 1);
    end
  endtask

  task automatic rand_client(input int idx, input int n);
    logic [31:0] x;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      x = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) x = 32'd0;
      do_req(idx, x);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    int b0, b1, b2, b3, bs, t_rel;
    logic [15:0] other;
    int gexp[4];

    vt[0] = '{1, 32'd144,        16'd12};
    vt[1] = '{0, 32'd0,          16'd0};
    vt[2] = '{1, 32'hFFFF_FFFF,  16'd65535};
    vt[3] = '{0, 32'h8000_0000,  16'd46340};
    vt[4] = '{1, 32'd1,          16'd1};
    vt[5] = '{0, 32'd99,         16'd9};
    vt[6] = '{1, 32'h3FFF_FFFF,  16'd32767};
    vt[7] = '{0, 32'h4000_0000,  16'd32768};
    gexp = '{0, 1, 0, 1};

    repeat (3) @(negedge clock);
    #1;
    chk("rst_ctl", {ack0, ack1, done0, done1, core_start, timeout}, 0);
    chk("rst_data", {root0, root1, core_xin}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single request, all-ones operand
    b0 = n_ack0;
    bs = n_start;
    do_req(0, 32'hFFFF_FFFF);
    chk("single_ack_cnt", n_ack0 - b0, 1);
    chk("single_start_cnt", n_start - bs, 1);
    chk("single_root0", root0, 16'd65535);
    chk("single_root1", root1, 16'd0);
    chk("lat_req_ack", t_ack - t_req, 1);
    chk("lat_ack_start", t_start - t_ack, 1);
    chk("lat_cdone_done", t_done - t_cdone, 2);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      other = (vt[i].sel == 0) ? root1 : root0;
      do_req(vt[i].sel, vt[i].x);
      if (vt[i].sel == 0) begin
        chk("vec_root0", root0, vt[i].exp);
        chk("vec_root1_kept", root1, other);
      end else begin
        chk("vec_root1", root1, vt[i].exp);
        chk("vec_root0_kept", root0, other);
      end
    end

    // Both requests held from reset: strict alternation
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    exp0.delete();
    exp1.delete();
    xin0 = 32'h8000_0000;
    xin1 = 32'd1;
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    glog.delete();
    b2 = n_done0 + n_done1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #1;
      if (n_done0 + n_done1 >= b2 + 4) begin
        ok = 1'b1;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("alt_four_done", ok, 1);
    repeat (5) @(negedge clock);
    #1;
    chk("alt_grant_count", glog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk("alt_grant_order", glog[i], gexp[i]);
    end
    chk("alt_root0", root0, 16'd46340);
    chk("alt_root1", root1, 16'd1);

    // Core busy holds off the start pulse
    bs = n_start;
    force_busy = 1'b1;
    @(negedge clock);
    #1;
    xin1 = 32'd0;
    req1 = 1'b1;
    wait_sig(1, 200, ok);
    req1 = 1'b0;
    chk("busy_ack", ok, 1);
    repeat (10) @(negedge clock);
    #1;
    chk("busy_no_start", n_start - bs, 0);
    t_rel = cyc;
    force_busy = 1'b0;
    wait_sig(4, 20, ok);
    chk("busy_start_seen", ok, 1);
    chk("busy_start_lat", t_start - t_rel, 1);
    wait_sig(3, 100, ok);
    chk("busy_done1", ok, 1);
    chk("busy_one_start", n_start - bs, 1);
    chk("busy_root1", root1, 16'd0);

    // Hung core: watchdog aborts with root 0
    m_hang = 1'b1;
    b0 = n_done0;
    do_req(0, 32'h1234_5678);
    chk("to_flag", timeout, 1);
    chk("to_lat", t_to - t_start, TO + 1);
    chk("to_done_lat", t_done - t_to, 1);
    chk("to_root0", root0, 16'd0);
    m_hang = 1'b0;
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    chk("spur_no_done", n_done0 - b0, 1);
    chk("spur_root0", root0, 16'd0);
    chk("spur_flag_kept", timeout, 1);
    clr_timeout = 1'b1;
    @(negedge clock);
    clr_timeout = 1'b0;
    #1;
    chk("to_cleared", timeout, 0);

    // Clear held while a timeout fires: set wins
    m_hang = 1'b1;
    clr_timeout = 1'b1;
    t_to = 0;
    do_req(1, 32'd49);
    chk("setclr_rose", t_to - t_start, TO + 1);
    chk("setclr_root1", root1, 16'd0);
    @(negedge clock);
    #1;
    chk("setclr_after", timeout, 0);
    clr_timeout = 1'b0;
    m_hang = 1'b0;

    // Reset during WAIT discards the operation
    @(negedge clock);
    #1;
    xin0 = 32'd10000;
    req0 = 1'b1;
    wait_sig(0, 200, ok);
    req0 = 1'b0;
    chk("rstw_ack", ok, 1);
    wait_sig(4, 20, ok);
    chk("rstw_start", ok, 1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rstw_ctl", {ack0, ack1, done0, done1, core_start, timeout}, 0);
    chk("rstw_data", {root0, root1, core_xin}, 0);
    exp0.delete();
    exp1.delete();
    b0 = n_done0;
    b1 = n_done1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    chk("rstw_no_done", (n_done0 - b0) + (n_done1 - b1), 0);
    do_req(1, 32'd144);
    chk("rstw_next_root1", root1, 16'd12);

    // Random interleaved traffic
    b0 = n_ack0;
    b1 = n_ack1;
    b2 = n_done0;
    b3 = n_done1;
    fork
      rand_client(0, 25);
      rand_client(1, 25);
    join
    repeat (5) @(negedge clock);
    #1;
    chk("rand_ack0", n_ack0 - b0, 25);
    chk("rand_ack1", n_ack1 - b1, 25);
    chk("rand_eq0", n_ack0 - b0, n_done0 - b2);
    chk("rand_eq1", n_ack1 - b1, n_done1 - b3);
    chk("rand_sb_empty", exp0.size() + exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
